adma_desc_fetch: RTL and testbench

- Descriptor fetch unit: the producer side of the descriptor interface that the DMA transfer state machine consumes.
- Walks a descriptor table in system RAM one byte at a time, assembles 12-byte descriptors, and resolves nop/link entries internally.
- Presents each transfer descriptor (valid_2, end_2, tran_2, block_size, desc_addr) to the DMA engine and holds it until the engine returns continue_1.

---
 rtl/adma_desc_fetch_pkg.sv | 28 ++
 rtl/adma_desc_fetch_if.sv | 35 +++
 rtl/adma_desc_shreg.sv | 42 ++++
 rtl/adma_desc_fetch.sv | 191 +++++++++++++++++++
 tb/tb_adma_desc_fetch.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adma_desc_fetch_pkg.sv
// Shared constants and state encoding for the ADMA descriptor fetch unit.
// Optional build macro: ADMA_LINK_GUARD_EN (nop/link loop guard).
package adma_pkg;

  localparam logic [1:0] ACT_NOP  = 2'b00;
  localparam logic [1:0] ACT_RSVD = 2'b01;
  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  localparam int DESC_BYTES = 12;

  localparam int ATTR_VALID = 0;
  localparam int ATTR_END   = 1;
  localparam int ATTR_ACT   = 4;

  localparam int OFF_ATTR = 0;
  localparam int OFF_LEN  = 2;
  localparam int OFF_ADDR = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PRESENT,
    S_ERROR
  } state_t;

endpackage

// File: rtl/adma_desc_fetch_if.sv
// RAM byte-read bus and descriptor hand-off bus of the fetch unit.
// master = fetch unit, slave = RAM / DMA engine side.
interface adma_desc_fetch_if #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 12
);
  logic              ram_rd;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_ack;
  logic              stop_2;
  logic              continue_1;
  logic              enable_2;
  logic              valid_2;
  logic              end_2;
  logic [1:0]        tran_2;
  logic [LEN_W-1:0]  block_size;
  logic [ADDR_W-1:0] desc_addr;

  modport master (
    output ram_rd, ram_addr,
    input  ram_data, ram_ack,
    input  stop_2, continue_1,
    output enable_2, valid_2, end_2,
    output tran_2, block_size, desc_addr
  );

  modport slave (
    input  ram_rd, ram_addr,
    output ram_data, ram_ack,
    output stop_2, continue_1,
    input  enable_2, valid_2, end_2,
    input  tran_2, block_size, desc_addr
  );
endinterface

// File: rtl/adma_desc_shreg.sv
// 12-byte descriptor capture register; bytes land by index on each ack.
// Exposes the decoded attr/length/address fields of the captured entry.
import adma_pkg::*;

module adma_desc_shreg #(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [3:0]        idx,
  input  logic [7:0]        data,
  output logic              valid,
  output logic              is_end,
  output logic [1:0]        act,
  output logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr
);

  logic [DESC_BYTES*8-1:0] q;
  logic [7:0]              attr;
  logic                    unused_q;

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q[{idx, 3'b000} +: 8] <= data;
  end

  assign attr   = q[OFF_ATTR*8 +: 8];
  assign valid  = attr[ATTR_VALID];
  assign is_end = attr[ATTR_END];
  assign act    = attr[ATTR_ACT +: 2];
  assign len    = q[OFF_LEN*8 +: LEN_W];
  assign addr   = q[OFF_ADDR*8 +: ADDR_W];

  // reserved byte, int bit and unused length bits
  assign unused_q = ^q;

endmodule

// File: rtl/adma_desc_fetch.sv
// ADMA descriptor fetch: walks the table byte-wise, resolves nop/link.
// Optional build macro: ADMA_LINK_GUARD_EN (error after MAX_SKIP skips).
import adma_pkg::*;

module adma_desc_fetch #(
  parameter int ADDR_W   = 64,
  parameter int LEN_W    = 12,
  parameter int MAX_SKIP = 8
) (
  input  logic              clk_in_1,
  input  logic              reset_1,
  input  logic              start,
  input  logic [ADDR_W-1:0] desc_base,
  adma_desc_fetch_if.master bus,
  output logic              error_1,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DESC_BYTES);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [3:0]        idx;
  logic              rd;
  logic [ADDR_W-1:0] addr_q;
  logic              en;
  logic              valid_q;
  logic              end_q;
  logic [1:0]        tran_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              ack_ok;
  logic              last;
  logic              restart;
  logic              guard_trip;
  logic              d_valid;
  logic              d_end;
  logic [1:0]        d_act;
  logic [LEN_W-1:0]  d_len;
  logic [ADDR_W-1:0] d_addr;

  assign ack_ok  = (state == S_FETCH) && rd && bus.ram_ack;
  assign last    = ack_ok && (idx == 4'(DESC_BYTES - 1));
  assign restart = start && ((state == S_IDLE) || (state == S_ERROR));

  adma_desc_shreg #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_shreg (
    .clk    (clk_in_1),
    .rst    (reset_1),
    .load   (ack_ok && !bus.stop_2),
    .idx    (idx),
    .data   (bus.ram_data),
    .valid  (d_valid),
    .is_end (d_end),
    .act    (d_act),
    .len    (d_len),
    .addr   (d_addr)
  );

`ifdef ADMA_LINK_GUARD_EN
  localparam int SK_W = $clog2(MAX_SKIP + 1);
  logic [SK_W-1:0] skip;

  assign guard_trip = (skip + SK_W'(1)) == SK_W'(MAX_SKIP);

  always_ff @(posedge clk_in_1) begin
    if (reset_1)
      skip <= '0;
    else if (!bus.stop_2) begin
      if (restart)
        skip <= '0;
      else if (state == S_DECODE && d_valid)
        skip <= (d_act == ACT_TRAN) ? '0 : skip + SK_W'(1);
    end
  end
`else
  logic unused_skip;
  assign unused_skip = ^32'(MAX_SKIP);
  assign guard_trip  = 1'b0;
`endif

  always_ff @(posedge clk_in_1) begin
    if (reset_1)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (last) state_nxt = S_DECODE;
      S_DECODE: begin
        if (!d_valid)
          state_nxt = S_ERROR;
        else begin
          case (d_act)
            ACT_TRAN:
              state_nxt = S_PRESENT;
            ACT_NOP, ACT_RSVD, ACT_LINK:
              state_nxt = guard_trip ? S_ERROR :
                          d_end      ? S_IDLE  : S_FETCH;
            default: ;
          endcase
        end
      end
      S_PRESENT:
        if (bus.continue_1)
          state_nxt = end_q ? S_IDLE : S_FETCH;
      S_ERROR: if (start) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
    // abort overrides every transition, including a restart
    if (bus.stop_2)
      state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_in_1) begin
    if (reset_1) begin
      ptr     <= '0;
      idx     <= '0;
      rd      <= 1'b0;
      addr_q  <= '0;
      en      <= 1'b0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      tran_q  <= '0;
      len_q   <= '0;
      daddr_q <= '0;
      error_1 <= 1'b0;
    end else if (bus.stop_2) begin
      rd <= 1'b0;
      en <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERROR:
          if (start) begin
            ptr     <= desc_base;
            idx     <= '0;
            error_1 <= 1'b0;
          end
        S_FETCH:
          // rd low for one cycle between bytes
          if (!rd) begin
            rd     <= 1'b1;
            addr_q <= ptr + ADDR_W'(idx);
          end else if (bus.ram_ack) begin
            rd  <= 1'b0;
            idx <= idx + 4'd1;
          end
        S_DECODE: begin
          idx <= '0;
          if (!d_valid || (d_act != ACT_TRAN && guard_trip))
            error_1 <= 1'b1;
          else if (d_act == ACT_TRAN) begin
            en      <= 1'b1;
            valid_q <= d_valid;
            end_q   <= d_end;
            tran_q  <= d_act;
            len_q   <= d_len;
            daddr_q <= d_addr;
          end else if (d_act == ACT_LINK)
            ptr <= d_addr;
          else
            ptr <= ptr + STEP;
        end
        S_PRESENT:
          if (bus.continue_1) begin
            en <= 1'b0;
            if (!end_q)
              ptr <= ptr + STEP;
          end
        default: ;
      endcase
    end
  end

  assign busy           = (state != S_IDLE) && (state != S_ERROR);
  assign bus.ram_rd     = rd;
  assign bus.ram_addr   = addr_q;
  assign bus.enable_2   = en;
  assign bus.valid_2    = valid_q;
  assign bus.end_2      = end_q;
  assign bus.tran_2     = tran_q;
  assign bus.block_size = len_q;
  assign bus.desc_addr  = daddr_q;

endmodule

// File: tb/tb_adma_desc_fetch.sv
// Directed bench for adma_desc_fetch: byte-RAM responder plus
// scenario tasks with hand-computed expected values.
module tb_adma_desc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] desc_base = '0;
  logic        error_1;
  logic        busy;

  adma_desc_fetch_if #(.ADDR_W(64), .LEN_W(12)) bus ();

  adma_desc_fetch #(
    .ADDR_W   (64),
    .LEN_W    (12),
    .MAX_SKIP (8)
  ) dut (
    .clk_in_1  (clk),
    .reset_1   (rst),
    .start     (start),
    .desc_base (desc_base),
    .bus       (bus),
    .error_1   (error_1),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  mem [logic [63:0]];
  logic [63:0] alog [$];
  int          ack_count = 0;
  int          lat = 1;
  bit          ram_en = 1'b1;
  int          wait_cnt = 0;
  int          rises = 0;
  logic        en_d = 1'b0;

  // RAM responder: ack one cycle, `lat` cycles after ram_rd is seen
  initial begin
    bus.ram_ack  = 1'b0;
    bus.ram_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ram_ack) begin
        bus.ram_ack = 1'b0;
      end else if (ram_en && bus.ram_rd === 1'b1) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          bus.ram_data = mem.exists(bus.ram_addr) ? mem[bus.ram_addr] : 8'h00;
          bus.ram_ack  = 1'b1;
          alog.push_back(bus.ram_addr);
          ack_count++;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.enable_2 === 1'b1 && !en_d)
      rises++;
    en_d = (bus.enable_2 === 1'b1);
  end

  task automatic put_desc(input logic [63:0] a, input logic [7:0] attr,
                          input logic [15:0] len, input logic [63:0] da);
    logic [95:0] d;
    d = {da, len, 8'h00, attr};
    for (int i = 0; i < 12; i++)
      mem[a + 64'(i)] = d[i*8 +: 8];
  endtask

  task automatic kick(input logic [63:0] base);
    @(negedge clk);
    start     = 1'b1;
    desc_base = base;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic pulse_continue;
    @(negedge clk);
    bus.continue_1 = 1'b1;
    @(negedge clk);
    bus.continue_1 = 1'b0;
  endtask

  task automatic wait_en(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.enable_2 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_err(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (error_1 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    nvec++; if (error_1 !== 1'b0) begin nerr++; $display("FAIL reset_err got=%0h exp=0", error_1); end
    nvec++; if (bus.ram_rd !== 1'b0) begin nerr++; $display("FAIL reset_rd got=%0h exp=0", bus.ram_rd); end
    nvec++; if (bus.enable_2 !== 1'b0) begin nerr++; $display("FAIL reset_en got=%0h exp=0", bus.enable_2); end
    nvec++; if (bus.block_size !== 12'h0) begin nerr++; $display("FAIL reset_len got=%0h exp=0", bus.block_size); end
    nvec++; if (bus.desc_addr !== 64'h0) begin nerr++; $display("FAIL reset_daddr got=%0h exp=0", bus.desc_addr); end
    nvec++; if (bus.ram_addr !== 64'h0) begin nerr++; $display("FAIL reset_raddr got=%0h exp=0", bus.ram_addr); end
  endtask

  task automatic test_single;
    bit ok;
    int bad;
    put_desc(64'h100, 8'h23, 16'h0200, 64'h8000);
    lat = 2;
    alog.delete();
    kick(64'h100);
    wait_en(400, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL single_timeout got=0 exp=1"); end
    nvec++; if (alog.size() != 12) begin nerr++; $display("FAIL single_nreads got=%0d exp=12", alog.size()); end
    bad = 0;
    for (int i = 0; i < alog.size(); i++)
      if (alog[i] !== 64'h100 + 64'(i)) bad++;
    nvec++; if (bad != 0) begin nerr++; $display("FAIL single_addrs got=%0d exp=0 bad", bad); end
    nvec++; if (bus.block_size !== 12'h200) begin nerr++; $display("FAIL single_len got=%0h exp=200", bus.block_size); end
    nvec++; if (bus.desc_addr !== 64'h8000) begin nerr++; $display("FAIL single_daddr got=%0h exp=8000", bus.desc_addr); end
    nvec++; if (bus.end_2 !== 1'b1) begin nerr++; $display("FAIL single_end got=%0h exp=1", bus.end_2); end
    nvec++; if (bus.valid_2 !== 1'b1) begin nerr++; $display("FAIL single_valid got=%0h exp=1", bus.valid_2); end
    nvec++; if (bus.tran_2 !== 2'b10) begin nerr++; $display("FAIL single_tran got=%0h exp=2", bus.tran_2); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy got=%0h exp=1", busy); end
    // start must be ignored while presenting
    kick(64'h900);
    repeat (2) @(negedge clk);
    nvec++; if (bus.enable_2 !== 1'b1) begin nerr++; $display("FAIL single_hold got=%0h exp=1", bus.enable_2); end
    nvec++; if (bus.desc_addr !== 64'h8000) begin nerr++; $display("FAIL single_holdaddr got=%0h exp=8000", bus.desc_addr); end
    pulse_continue();
    nvec++; if (bus.enable_2 !== 1'b0) begin nerr++; $display("FAIL single_drop got=%0h exp=0", bus.enable_2); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL single_idle got=%0h exp=0", busy); end
    repeat (4) @(negedge clk);
    nvec++; if (alog.size() != 12) begin nerr++; $display("FAIL single_noextra got=%0d exp=12", alog.size()); end
    nvec++; if (bus.block_size !== 12'h200) begin nerr++; $display("FAIL single_fieldhold got=%0h exp=200", bus.block_size); end
  endtask

  task automatic test_chain;
    bit ok;
    put_desc(64'h0, 8'h21, 16'h0010, 64'h1000);
    put_desc(64'hC, 8'h23, 16'h0020, 64'h2000);
    lat = 1;
    alog.delete();
    kick(64'h0);
    wait_en(400, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL chain_timeout1 got=0 exp=1"); end
    nvec++; if (bus.desc_addr !== 64'h1000) begin nerr++; $display("FAIL chain_daddr1 got=%0h exp=1000", bus.desc_addr); end
    nvec++; if (bus.end_2 !== 1'b0) begin nerr++; $display("FAIL chain_end1 got=%0h exp=0", bus.end_2); end
    alog.delete();
    pulse_continue();
    wait_en(400, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL chain_timeout2 got=0 exp=1"); end
    nvec++; if (alog.size() != 12 || alog[0] !== 64'hC) begin nerr++; $display("FAIL chain_addr2 got=%0d exp=12", alog.size()); end
    nvec++; if (bus.desc_addr !== 64'h2000) begin nerr++; $display("FAIL chain_daddr2 got=%0h exp=2000", bus.desc_addr); end
    nvec++; if (bus.block_size !== 12'h20) begin nerr++; $display("FAIL chain_len2 got=%0h exp=20", bus.block_size); end
    pulse_continue();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL chain_idle got=%0h exp=0", busy); end
  endtask

  task automatic test_wrap;
    bit ok;
    put_desc(64'hFFFF_FFFF_FFFF_FFF8, 8'h21, 16'h0001, 64'hA);
    put_desc(64'h4, 8'h23, 16'h0002, 64'hB);
    alog.delete();
    kick(64'hFFFF_FFFF_FFFF_FFF8);
    wait_en(400, ok);
    nvec++; if (!ok || alog[8] !== 64'h0) begin nerr++; $display("FAIL wrap_byte8 got=%0h exp=0", alog[8]); end
    nvec++; if (bus.desc_addr !== 64'hA) begin nerr++; $display("FAIL wrap_daddr1 got=%0h exp=a", bus.desc_addr); end
    alog.delete();
    pulse_continue();
    wait_en(400, ok);
    nvec++; if (!ok || alog[0] !== 64'h4) begin nerr++; $display("FAIL wrap_next got=%0h exp=4", alog[0]); end
    nvec++; if (bus.desc_addr !== 64'hB) begin nerr++; $display("FAIL wrap_daddr2 got=%0h exp=b", bus.desc_addr); end
    pulse_continue();
  endtask

  task automatic test_link;
    bit ok;
    int r0;
    put_desc(64'h600, 8'h31, 16'h0000, 64'h400);
    put_desc(64'h400, 8'h23, 16'h0044, 64'h9000);
    alog.delete();
    r0 = rises;
    kick(64'h600);
    wait_en(600, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL link_timeout got=0 exp=1"); end
    nvec++; if (alog.size() != 24 || alog[12] !== 64'h400) begin nerr++; $display("FAIL link_target got=%0d exp=24", alog.size()); end
    nvec++; if (bus.desc_addr !== 64'h9000) begin nerr++; $display("FAIL link_daddr got=%0h exp=9000", bus.desc_addr); end
    nvec++; if (bus.block_size !== 12'h44) begin nerr++; $display("FAIL link_len got=%0h exp=44", bus.block_size); end
    pulse_continue();
    repeat (3) @(negedge clk);
    nvec++; if (rises - r0 != 1) begin nerr++; $display("FAIL link_windows got=%0d exp=1", rises - r0); end
  endtask

  task automatic test_invalid;
    bit ok;
    put_desc(64'h200, 8'h20, 16'h0011, 64'h1234);
    put_desc(64'h40, 8'h23, 16'h0007, 64'h40000);
    kick(64'h200);
    wait_err(400, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL inv_err got=%0h exp=1", error_1); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL inv_busy got=%0h exp=0", busy); end
    repeat (3) @(negedge clk);
    nvec++; if (error_1 !== 1'b1 || bus.ram_rd !== 1'b0) begin nerr++; $display("FAIL inv_sticky got=%0h exp=1", error_1); end
    nvec++; if (bus.enable_2 !== 1'b0) begin nerr++; $display("FAIL inv_en got=%0h exp=0", bus.enable_2); end
    alog.delete();
    kick(64'h40);
    nvec++; if (error_1 !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL inv_clear got=%0h exp=0", error_1); end
    wait_en(400, ok);
    nvec++; if (!ok || alog[0] !== 64'h40) begin nerr++; $display("FAIL inv_refetch got=%0h exp=40", alog[0]); end
    nvec++; if (bus.block_size !== 12'h7) begin nerr++; $display("FAIL inv_len got=%0h exp=7", bus.block_size); end
    pulse_continue();
  endtask

  task automatic test_abort;
    bit ok;
    put_desc(64'h300, 8'h23, 16'h0055, 64'hBEEF);
    lat = 4;
    alog.delete();
    kick(64'h300);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (alog.size() == 5 && bus.ram_rd === 1'b1) begin ok = 1'b1; break; end
    end
    nvec++; if (!ok) begin nerr++; $display("FAIL abort_reach got=%0d exp=5", alog.size()); end
    bus.stop_2 = 1'b1;
    @(negedge clk);
    bus.stop_2 = 1'b0;
    nvec++; if (bus.ram_rd !== 1'b0) begin nerr++; $display("FAIL abort_rd got=%0h exp=0", bus.ram_rd); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL abort_busy got=%0h exp=0", busy); end
    ram_en = 1'b0;
    bus.ram_data = 8'hFF;
    bus.ram_ack = 1'b1;
    @(negedge clk);
    bus.ram_ack = 1'b0;
    repeat (2) @(negedge clk);
    nvec++; if (busy !== 1'b0 || bus.enable_2 !== 1'b0) begin nerr++; $display("FAIL abort_lateack got=%0h exp=0", busy); end
    // start and stop together in IDLE: stay idle
    start = 1'b1; bus.stop_2 = 1'b1; desc_base = 64'h300;
    @(negedge clk);
    start = 1'b0; bus.stop_2 = 1'b0;
    @(negedge clk);
    nvec++; if (busy !== 1'b0 || bus.ram_rd !== 1'b0) begin nerr++; $display("FAIL abort_startstop got=%0h exp=0", busy); end
    ram_en = 1'b1;
    lat = 1;
    alog.delete();
    kick(64'h300);
    wait_en(400, ok);
    nvec++; if (!ok || alog.size() != 12 || alog[0] !== 64'h300) begin nerr++; $display("FAIL abort_refetch got=%0d exp=12", alog.size()); end
    nvec++; if (bus.block_size !== 12'h55) begin nerr++; $display("FAIL abort_len got=%0h exp=55", bus.block_size); end
    pulse_continue();
  endtask

  task automatic test_guard;
    bit ok;
    put_desc(64'h700, 8'h31, 16'h0000, 64'h700);
    ack_count = 0;
    kick(64'h700);
`ifdef ADMA_LINK_GUARD_EN
    wait_err(2000, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL guard_err got=%0h exp=1", error_1); end
    nvec++; if (ack_count != 96) begin nerr++; $display("FAIL guard_acks got=%0d exp=96", ack_count); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL guard_busy got=%0h exp=0", busy); end
`else
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ack_count >= 108) begin ok = 1'b1; break; end
    end
    nvec++; if (!ok) begin nerr++; $display("FAIL loop_acks got=%0d exp=108", ack_count); end
    nvec++; if (error_1 !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL loop_noerr got=%0h exp=0", error_1); end
    @(negedge clk);
    bus.stop_2 = 1'b1;
    @(negedge clk);
    bus.stop_2 = 1'b0;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL loop_stop got=%0h exp=0", busy); end
`endif
  endtask

  initial begin
    bus.stop_2     = 1'b0;
    bus.continue_1 = 1'b0;
    test_reset();
    test_single();
    test_chain();
    test_wrap();
    test_link();
    test_invalid();
    test_abort();
    test_guard();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
